// File: rtl/mux_nto1_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_reg
// Brief    : N-to-1 valid/ready multiplexer with a registered output stage,
//            sticky bad-select flag and accepted-beat counter. Define
//            MUX_CAL_EN to apply f(x) = (x << 2) + 1 on the registered path.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        beat_cnt
);

  // One extra bit so NUM_IN == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_space;
  logic             w_sel_ok;
  logic             w_grant_ok;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_valid;
  logic [WIDTH-1:0] w_f;

  assign w_space    = !r_valid || out_ready;
  assign w_sel_ok   = ({1'b0, sel} < c_num_in);
  assign w_grant_ok = w_sel_ok && w_space && !rst;

  // Out-of-range selects fall through to zero / not-valid.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        w_sel_valid = in_valid[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = w_grant_ok && (sel == SEL_W'(gi));
    end
  endgenerate

  assign w_accept = w_grant_ok && w_sel_valid;

  generate
    if (1) begin : g_calc
`ifdef MUX_CAL_EN
      assign w_f = (w_sel_data << 2) + WIDTH'(1);
`else
      assign w_f = w_sel_data;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= w_f;
        r_sel   <= sel;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (w_space) begin
        r_valid <= 1'b0;
      end
      if (!w_sel_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;
  assign sel_err   = r_err;
  assign beat_cnt  = r_cnt;

endmodule
`default_nettype wire
